// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the 4th byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  // Bytes shift in from the top so the first byte of a word lands in [7:0].
  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    word       = {byte_data, buf_q};
    word_valid = byte_en && !clear && (cnt_q == 2'(WORD_BYTES - 1));
    if (clear) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      buf_d = {byte_data, buf_q[23:8]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction-memory word writes.
// Optional trailing XOR checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = ST_CHECK;
`else
  localparam state_e POST_DATA = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, hold_q, done_q, err_q;
  logic              accept, asm_clear, asm_en, word_valid;
  logic [31:0]       asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept = byte_valid && ready_q;
  assign asm_en = accept && (state_q == ST_DATA);

  imem_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_en    (asm_en),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d   = ST_LEN_LO;
          widx_d    = '0;
          asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          if ({1'b0, byte_data, len_q[7:0]} > MAX_WORDS)
            state_d = ST_ERR;
          else if ({byte_data, len_q[7:0]} == 16'd0)
            state_d = POST_DATA;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (word_valid) begin
            we_d    = 1'b1;
            addr_d  = widx_q;
            wdata_d = asm_word;
            widx_d  = widx_q + ADDR_W'(1);
            if ((17'(widx_q) + 17'd1) == {1'b0, len_q})
              state_d = POST_DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept)
          state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Status flags are registered from the next state so they track state_q exactly.
      ready_q <= (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                 (state_d == ST_DATA)   || (state_d == ST_CHECK);
      hold_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = hold_q && !err_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; expected writes derived from the byte stream.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int word0_acc_cyc = 0;

  logic [39:0] got_q[$];
  int          we_cyc_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  chk_byte;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset && imem_we) begin
      got_q.push_back({imem_addr, imem_wdata});
      we_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
      if (gap == 5) chk("stall_ready_held", {63'd0, byte_ready}, 64'd1);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (!byte_ready && tries < 50) begin
      @(negedge clock);
      tries++;
    end
    if (!byte_ready) chk("accept_timeout", {63'd0, byte_ready}, 64'd1);
    @(negedge clock);
    last_acc_cyc = cyc;
  endtask

  task automatic do_load(input int n, input int maxgap, input int stall_at);
    got_q.delete();
    we_cyc_q.delete();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    send_byte(n[7:0], $urandom_range(0, maxgap));
    send_byte(n[15:8], $urandom_range(0, maxgap));
    if (n <= (1 << ADDR_W)) begin
      foreach (data_q[i]) begin
        send_byte(data_q[i], (i == stall_at) ? 5 : int'($urandom_range(0, maxgap)));
        if (i == 3) word0_acc_cyc = last_acc_cyc;
      end
      if (CSUM) send_byte(chk_byte, $urandom_range(0, maxgap));
    end
    byte_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // Reference: N words, word k = bytes 4k..4k+3 little-endian, error on oversize or bad checksum.
  task automatic check_load(input string tag, input int n);
    bit          exp_err;
    int          exp_n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_err = (n > (1 << ADDR_W));
    exp_n   = exp_err ? 0 : n;
    x = 8'h00;
    foreach (data_q[i]) x ^= data_q[i];
    if (!exp_err && CSUM && (chk_byte != x)) exp_err = 1'b1;
    chk($sformatf("%s_nwrites", tag), 64'(got_q.size()), 64'(exp_n));
    for (int k = 0; k < exp_n && k < got_q.size(); k++) begin
      w = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
      chk($sformatf("%s_wr%0d", tag, k), 64'(got_q[k]), 64'({k[7:0], w}));
    end
    chk($sformatf("%s_done", tag),  {63'd0, done},     {63'd0, !exp_err});
    chk($sformatf("%s_error", tag), {63'd0, error},    {63'd0, exp_err});
    chk($sformatf("%s_hold", tag),  {63'd0, cpu_hold}, {63'd0, exp_err});
    chk($sformatf("%s_busy", tag),  {63'd0, busy},     64'd0);
    chk($sformatf("%s_ready", tag), {63'd0, byte_ready}, 64'd0);
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (data_q[i]) x ^= data_q[i];
    return x;
  endfunction

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_flags", {57'd0, byte_ready, imem_we, cpu_hold, busy, done, error, 1'b0}, 64'd0);
    chk("rst_addr_data", {24'd0, imem_addr, imem_wdata}, 64'd0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    chk("idle_ready", {62'd0, byte_ready, cpu_hold}, 64'd0);

    // Three-word directed load
    data_q = '{8'h06, 8'h00, 8'h00, 8'h14, 8'h02, 8'h02, 8'h12, 8'h8B, 8'h02, 8'h00, 8'h00, 8'h94};
    chk_byte = xor_all();
    do_load(3, 0, -1);
    chk("dir_w0", 64'(got_q.size() > 0 ? got_q[0] : 40'h0), 64'({8'd0, 32'h14000006}));
    chk("dir_w1", 64'(got_q.size() > 1 ? got_q[1] : 40'h0), 64'({8'd1, 32'h8B120202}));
    chk("dir_w2", 64'(got_q.size() > 2 ? got_q[2] : 40'h0), 64'({8'd2, 32'h94000002}));
    check_load("dir3", 3);

    // Zero-length load
    data_q.delete();
    chk_byte = 8'h00;
    do_load(0, 1, -1);
    check_load("n0", 0);

    // Oversize header 257
    do_load(257, 1, -1);
    check_load("n257", 257);

    // Stall mid-word; write must land the cycle after the 4th byte
    data_q = '{8'h06, 8'h00, 8'h00, 8'h14};
    chk_byte = xor_all();
    do_load(1, 0, 2);
    check_load("stall", 1);
    chk("stall_we_cycle", 64'(we_cyc_q.size() > 0 ? we_cyc_q[0] : -1), 64'(word0_acc_cyc));

    // Reset after two data bytes
    got_q.delete();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_flags", {58'd0, imem_we, cpu_hold, busy, done, error, byte_ready}, 64'd0);
    chk("midrst_addr_data", {24'd0, imem_addr, imem_wdata}, 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("midrst_nwrites", 64'(got_q.size()), 64'd0);
    chk("midrst_idle", {62'd0, done, cpu_hold}, 64'd0);
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    chk_byte = xor_all();
    do_load(2, 1, -1);
    check_load("postrst", 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    data_q = '{8'h06, 8'h00, 8'h00, 8'h14};
    chk_byte = 8'h12;
    do_load(1, 0, -1);
    chk("csum_good_done", {63'd0, done}, 64'd1);
    check_load("csum_good", 1);
    chk_byte = 8'h13;
    do_load(1, 0, -1);
    chk("csum_bad_err", {63'd0, error}, 64'd1);
    check_load("csum_bad", 1);
`endif

    // Full memory boundary: 256 words
    data_q.delete();
    for (int i = 0; i < 1024; i++) data_q.push_back(8'($urandom));
    chk_byte = xor_all();
    do_load(256, 0, -1);
    check_load("n256", 256);

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 6);
      data_q.delete();
      for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
      chk_byte = xor_all();
      if (CSUM && $urandom_range(0, 1) == 1) chk_byte ^= 8'($urandom_range(1, 255));
      do_load(n, 3, -1);
      check_load($sformatf("rnd%0d", t), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
